// File: rtl/kmer_pkg.sv
// Shared widths, bit-array layout, hash record payload and FSM states
// for the k-mer counter insertion writer.
package kmer_pkg;

    localparam int unsigned NUM_KMERS    = 208;
    localparam int unsigned SAT_MAX      = 3;
    localparam int unsigned WORD_W       = 64;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned BA_H0_W      = 7;
    localparam int unsigned BA_HX_W      = 5;
    localparam int unsigned ADDR_W       = BA_H0_W;
    localparam int unsigned BA_HALF_W    = BA_H0_W + 4 * BA_HX_W;
    localparam int unsigned BA_EVEN_BASE = 0;
    localparam int unsigned BA_ODD_BASE  = 32;

    // Field order matches the bit-array half: h0 in the MSBs, h4 in the LSBs.
    typedef struct packed {
        logic [BA_H0_W-1:0] h0;
        logic [BA_HX_W-1:0] h1;
        logic [BA_HX_W-1:0] h2;
        logic [BA_HX_W-1:0] h3;
        logic [BA_HX_W-1:0] h4;
    } hash_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_READ,
        ST_CAPT,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sat_field_inc.sv
// Saturating increment of one 2-bit counter field inside a 64-bit SRAM word.
module sat_field_inc
    import kmer_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [5:0]        off_i,
    output logic [WORD_W-1:0] word_o,
    output logic              sat_o
);

    logic [1:0] field;

    always_comb begin
        field  = word_i[off_i +: 2];
        sat_o  = (field >= 2'(SAT_MAX));
        word_o = word_i;
        if (!sat_o) begin
            word_o[off_i +: 2] = field + 2'd1;
        end
    end

endmodule

// File: rtl/kmer_counter_insert.sv
// Insertion writer: read-modify-write of four 2-bit counters per k-mer and
// packing of the hash record into the bit-array SRAM, two records per word.
module kmer_counter_insert
    import kmer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [BA_H0_W-1:0]  LFSR0_data,
    input  logic [BA_HX_W-1:0]  LFSR1_data,
    input  logic [BA_HX_W-1:0]  LFSR2_data,
    input  logic [BA_HX_W-1:0]  LFSR3_data,
    input  logic [BA_HX_W-1:0]  LFSR4_data,
    input  logic [WORD_W-1:0]   dataout1,
    input  logic [WORD_W-1:0]   dataout2,
    input  logic [WORD_W-1:0]   dataout3,
    input  logic [WORD_W-1:0]   dataout4,
    output logic [ADDR_W-1:0]   address,
    output logic                CSB1,
    output logic                WEB1,
    output logic                OEB1,
    output logic [WORD_W-1:0]   datain1,
    output logic [WORD_W-1:0]   datain2,
    output logic [WORD_W-1:0]   datain3,
    output logic [WORD_W-1:0]   datain4,
    output logic [ADDR_W-1:0]   address_ba,
    output logic                CSB1_ba,
    output logic                WEB1_ba,
    output logic [WORD_W-1:0]   datain_ba,
    output logic [CNT_W-1:0]    kmer_count,
    output logic [CNT_W-1:0]    sat_hits,
    output logic                busy,
    output logic                done
);

    state_t                      state_q, state_d;
    hash_rec_t                   rec_q, rec_d;
    logic                        last_q, last_d, par_q, par_d;
    logic [BA_HALF_W-1:0]        pack_q, pack_d;
    logic [ADDR_W-1:0]           address_q, address_d, address_ba_q, address_ba_d;
    logic                        csb1_q, csb1_d, web1_q, web1_d, oeb1_q, oeb1_d;
    logic                        csb1_ba_q, csb1_ba_d, web1_ba_q, web1_ba_d;
    logic [3:0][WORD_W-1:0]      datain_q, datain_d;
    logic [WORD_W-1:0]           datain_ba_q, datain_ba_d;
    logic [CNT_W-1:0]            kmer_count_q, kmer_count_d, sat_hits_q, sat_hits_d;
    logic                        in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;

    logic [3:0][WORD_W-1:0]      rd_word, new_word;
    logic [3:0][BA_HX_W-1:0]     idx;
    logic [3:0]                  sat;
    logic [CNT_W:0]              sat_sum;
    logic [CNT_W-1:0]            cnt_inc;
    logic [WORD_W-1:0]           ba_word;

    assign rd_word = {dataout4, dataout3, dataout2, dataout1};
    assign idx     = {rec_q.h4, rec_q.h3, rec_q.h2, rec_q.h1};

    for (genvar k = 0; k < 4; k++) begin : g_inc
        sat_field_inc u_inc (
            .word_i (rd_word[k]),
            .off_i  ({idx[k], 1'b0}),
            .word_o (new_word[k]),
            .sat_o  (sat[k])
        );
    end

    // Even records land in the low half; an odd record completes the word with the held even half.
    always_comb begin
        ba_word = '0;
        ba_word[BA_EVEN_BASE +: BA_HALF_W] = par_q ? pack_q : rec_q;
        if (par_q) begin
            ba_word[BA_ODD_BASE +: BA_HALF_W] = rec_q;
        end
        sat_sum = {1'b0, sat_hits_q} + (CNT_W+1)'(sat[0]) + (CNT_W+1)'(sat[1])
                + (CNT_W+1)'(sat[2]) + (CNT_W+1)'(sat[3]);
        cnt_inc = kmer_count_q + CNT_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        rec_d        = rec_q;
        last_d       = last_q;
        par_d        = par_q;
        pack_d       = pack_q;
        address_d    = address_q;
        address_ba_d = address_ba_q;
        csb1_d       = 1'b1;
        web1_d       = 1'b1;
        oeb1_d       = 1'b1;
        csb1_ba_d    = 1'b1;
        web1_ba_d    = 1'b1;
        datain_d     = datain_q;
        datain_ba_d  = datain_ba_q;
        kmer_count_d = kmer_count_q;
        sat_hits_d   = sat_hits_q;
        in_ready_d   = 1'b0;
        done_d       = done_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_ACCEPT;
                    kmer_count_d = '0;
                    sat_hits_d   = '0;
                    done_d       = 1'b0;
                    in_ready_d   = 1'b1;
                end
            end
            ST_ACCEPT: begin
                in_ready_d = 1'b1;
                if (in_valid) begin
                    state_d    = ST_READ;
                    rec_d      = {LFSR0_data, LFSR1_data, LFSR2_data, LFSR3_data, LFSR4_data};
                    last_d     = in_last;
                    par_d      = kmer_count_q[0];
                    in_ready_d = 1'b0;
                    address_d  = LFSR0_data;
                    csb1_d     = 1'b0;
                    oeb1_d     = 1'b0;
                end
            end
            ST_READ: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                state_d    = ST_WRITE;
                datain_d   = new_word;
                csb1_d     = 1'b0;
                web1_d     = 1'b0;
                sat_hits_d = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
                if (!par_q) begin
                    pack_d = rec_q;
                end
                if (par_q || last_q) begin
                    csb1_ba_d    = 1'b0;
                    web1_ba_d    = 1'b0;
                    address_ba_d = ADDR_W'(kmer_count_q >> 1);
                    datain_ba_d  = ba_word;
                end
            end
            ST_WRITE: begin
                kmer_count_d = cnt_inc;
                if (last_q || (cnt_inc == CNT_W'(NUM_KMERS))) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ST_ACCEPT;
                    in_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ACCEPT) || (state_d == ST_READ)
              || (state_d == ST_CAPT)   || (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rec_q        <= '0;
            last_q       <= 1'b0;
            par_q        <= 1'b0;
            pack_q       <= '0;
            address_q    <= '0;
            address_ba_q <= '0;
            csb1_q       <= 1'b1;
            web1_q       <= 1'b1;
            oeb1_q       <= 1'b1;
            csb1_ba_q    <= 1'b1;
            web1_ba_q    <= 1'b1;
            datain_q     <= '0;
            datain_ba_q  <= '0;
            kmer_count_q <= '0;
            sat_hits_q   <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rec_q        <= rec_d;
            last_q       <= last_d;
            par_q        <= par_d;
            pack_q       <= pack_d;
            address_q    <= address_d;
            address_ba_q <= address_ba_d;
            csb1_q       <= csb1_d;
            web1_q       <= web1_d;
            oeb1_q       <= oeb1_d;
            csb1_ba_q    <= csb1_ba_d;
            web1_ba_q    <= web1_ba_d;
            datain_q     <= datain_d;
            datain_ba_q  <= datain_ba_d;
            kmer_count_q <= kmer_count_d;
            sat_hits_q   <= sat_hits_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign address    = address_q;
    assign CSB1       = csb1_q;
    assign WEB1       = web1_q;
    assign OEB1       = oeb1_q;
    assign datain1    = datain_q[0];
    assign datain2    = datain_q[1];
    assign datain3    = datain_q[2];
    assign datain4    = datain_q[3];
    assign address_ba = address_ba_q;
    assign CSB1_ba    = csb1_ba_q;
    assign WEB1_ba    = web1_ba_q;
    assign datain_ba  = datain_ba_q;
    assign kmer_count = kmer_count_q;
    assign sat_hits   = sat_hits_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_kmer_counter_insert.sv
// Bench for kmer_counter_insert: SRAM model, arithmetic reference of the
// counter and bit-array contents, and directed records.
module tb_kmer_counter_insert;

    localparam int SAT = 3;
    localparam int NK  = 208;

    logic clk = 1'b0;
    logic reset, start, in_valid, in_last;
    logic [6:0] l0;
    logic [4:0] l1, l2, l3, l4;
    logic [63:0] dataout1, dataout2, dataout3, dataout4;
    logic in_ready, CSB1, WEB1, OEB1, CSB1_ba, WEB1_ba, busy, done;
    logic [6:0] address, address_ba;
    logic [63:0] datain1, datain2, datain3, datain4, datain_ba;
    logic [7:0] kmer_count, sat_hits;

    always #5 clk = ~clk;

    kmer_counter_insert dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last),
        .LFSR0_data(l0), .LFSR1_data(l1), .LFSR2_data(l2), .LFSR3_data(l3), .LFSR4_data(l4),
        .dataout1(dataout1), .dataout2(dataout2), .dataout3(dataout3), .dataout4(dataout4),
        .address(address), .CSB1(CSB1), .WEB1(WEB1), .OEB1(OEB1),
        .datain1(datain1), .datain2(datain2), .datain3(datain3), .datain4(datain4),
        .address_ba(address_ba), .CSB1_ba(CSB1_ba), .WEB1_ba(WEB1_ba), .datain_ba(datain_ba),
        .kmer_count(kmer_count), .sat_hits(sat_hits), .busy(busy), .done(done)
    );

    // Counter SRAMs: synchronous read, registered data the cycle after the strobe.
    logic [63:0] sram [4][128];
    logic [63:0] dout [4];
    logic clr_mem, pl_en;
    logic [1:0] pl_k;
    logic [6:0] pl_a;
    logic [63:0] pl_d;

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int k = 0; k < 4; k++)
                for (int a = 0; a < 128; a++) sram[k][a] <= 64'h0;
        end else if (pl_en) begin
            sram[pl_k][pl_a] <= pl_d;
        end else if (!CSB1 && !WEB1) begin
            sram[0][address] <= datain1;
            sram[1][address] <= datain2;
            sram[2][address] <= datain3;
            sram[3][address] <= datain4;
        end
        if (!CSB1 && !OEB1)
            for (int k = 0; k < 4; k++) dout[k] <= sram[k][address];
    end

    assign dataout1 = dout[0];
    assign dataout2 = dout[1];
    assign dataout3 = dout[2];
    assign dataout4 = dout[3];

    typedef struct packed { logic [6:0] a; logic [3:0][63:0] d; } pwr_t;
    typedef struct packed { logic [6:0] a; logic [63:0] w; } bwr_t;

    pwr_t exp_p[$];
    bwr_t exp_b[$];
    pwr_t last_p, mon_p;
    bwr_t last_b, mon_b;
    int n_ba_wr = 0;
    int checks = 0;
    int failures = 0;

    int m_count, m_sat;
    logic m_done;
    logic [63:0] m_held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Every write strobe must match the next expected write from the reference.
    always @(negedge clk) begin
        if (!reset) begin
            if (!CSB1 && !WEB1) begin
                chk("oeb_during_write", 64'(OEB1), 64'h1);
                if (exp_p.size() == 0) fail_now("unexpected_port_write");
                else begin
                    mon_p = exp_p.pop_front();
                    chk("wr_addr", 64'(address), 64'(mon_p.a));
                    chk("wr_d1", datain1, mon_p.d[0]);
                    chk("wr_d2", datain2, mon_p.d[1]);
                    chk("wr_d3", datain3, mon_p.d[2]);
                    chk("wr_d4", datain4, mon_p.d[3]);
                end
                last_p = {address, datain4, datain3, datain2, datain1};
            end
            if (!CSB1_ba && !WEB1_ba) begin
                n_ba_wr++;
                if (exp_b.size() == 0) fail_now("unexpected_ba_write");
                else begin
                    mon_b = exp_b.pop_front();
                    chk("ba_addr", 64'(address_ba), 64'(mon_b.a));
                    chk("ba_word", datain_ba, mon_b.w);
                end
                last_b = {address_ba, datain_ba};
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_count = 0; m_sat = 0; m_done = 1'b0;
        @(negedge clk);
        chk("start_ready", 64'(in_ready), 64'h1);
        chk("start_done", 64'(done), 64'h0);
        chk("start_count", 64'(kmer_count), 64'h0);
    endtask

    task automatic preload(input logic [1:0] k, input logic [6:0] a, input logic [63:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_k = k; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic send_rec(input logic [6:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] a3, input logic [4:0] a4, input logic last);
        int t, nsat;
        logic [4:0] hs [4];
        logic [63:0] w, half;
        logic [1:0] f;
        pwr_t e;
        bwr_t b;
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        if (!in_ready) begin fail_now("accept_timeout"); return; end
        in_valid = 1'b1; in_last = last;
        l0 = a0; l1 = a1; l2 = a2; l3 = a3; l4 = a4;
        hs[0] = a1; hs[1] = a2; hs[2] = a3; hs[3] = a4;
        e.a = a0; nsat = 0;
        for (int k = 0; k < 4; k++) begin
            w = sram[k][a0];
            f = 2'((w >> (2 * hs[k])) & 64'h3);
            if (int'(f) == SAT) nsat++;
            else w = w + (64'h1 << (2 * hs[k]));
            e.d[k] = w;
        end
        exp_p.push_back(e);
        m_sat = (m_sat + nsat > 255) ? 255 : m_sat + nsat;
        half = 64'(a0) * 64'd1048576 + 64'(a1) * 64'd32768 + 64'(a2) * 64'd1024
             + 64'(a3) * 64'd32 + 64'(a4);
        b.a = 7'(m_count / 2);
        if (m_count % 2 == 0) begin
            m_held = half;
            b.w = half;
            if (last) exp_b.push_back(b);
        end else begin
            b.w = (half << 32) | m_held;
            exp_b.push_back(b);
        end
        m_count++;
        m_done = last || (m_count == NK);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rd_strobe", 64'({CSB1, OEB1, WEB1}), 64'b001);
        chk("rd_addr", 64'(address), 64'(a0));
        chk("rd_busy", 64'(busy), 64'h1);
        @(negedge clk);
        chk("idle_strobe", 64'({CSB1, WEB1}), 64'b11);
        @(negedge clk);
        chk("wr_strobe", 64'({CSB1, WEB1}), 64'b00);
        @(negedge clk);
        chk("post_ready", 64'(in_ready), 64'(!m_done));
        chk("post_done", 64'(done), 64'(m_done));
        chk("post_count", 64'(kmer_count), 64'(m_count));
        chk("post_sat", 64'(sat_hits), 64'(m_sat));
    endtask

    int ba_before;

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        l0 = '0; l1 = '0; l2 = '0; l3 = '0; l4 = '0;
        pl_en = 1'b0; pl_k = '0; pl_a = '0; pl_d = '0;
        clr_mem = 1'b1;
        m_count = 0; m_sat = 0; m_done = 1'b0; m_held = '0;
        repeat (2) @(posedge clk);
        #1 clr_mem = 1'b0;

        // Reset values, then idle without start.
        @(negedge clk);
        chk("rst_bars", 64'({CSB1, WEB1, OEB1, CSB1_ba, WEB1_ba}), 64'h1f);
        chk("rst_ready_done_busy", 64'({in_ready, done, busy}), 64'h0);
        chk("rst_addr", 64'({address, address_ba}), 64'h0);
        chk("rst_datain", datain1 | datain2 | datain3 | datain4 | datain_ba, 64'h0);
        chk("rst_counts", 64'({kmer_count, sat_hits}), 64'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ready", 64'(in_ready), 64'h0);
        chk("idle_done", 64'(done), 64'h0);

        // Single last record on zeroed counters.
        do_start();
        send_rec(7'd5, 5'd3, 5'd0, 5'd31, 5'd16, 1'b1);
        chk("lit_addr", 64'(last_p.a), 64'd5);
        chk("lit_d1", last_p.d[0], 64'h40);
        chk("lit_d2", last_p.d[1], 64'h1);
        chk("lit_d3", last_p.d[2], 64'h4000_0000_0000_0000);
        chk("lit_d4", last_p.d[3], 64'h1_0000_0000);
        chk("lit_ba_addr", 64'(last_b.a), 64'h0);
        chk("lit_ba_word", last_b.w, 64'h0000_0000_0051_83f0);
        chk("lit_done", 64'(done), 64'h1);

        // Saturated field and a carry-free increment in an all-ones word.
        preload(2'd0, 7'd9, 64'hC0);
        preload(2'd1, 7'd9, 64'hFFFF_FFFF_FFFF_FFFE);
        do_start();
        send_rec(7'd9, 5'd3, 5'd0, 5'd1, 5'd1, 1'b1);
        chk("lit_sat_d1", last_p.d[0], 64'hC0);
        chk("lit_sat_d2", last_p.d[1], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lit_sat_hits", 64'(sat_hits), 64'h1);

        // Even record held, odd record completes the bit-array word.
        do_start();
        ba_before = n_ba_wr;
        send_rec(7'd1, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0);
        chk("no_ba_even", 64'(n_ba_wr), 64'(ba_before));
        send_rec(7'd2, 5'd2, 5'd2, 5'd2, 5'd2, 1'b1);
        chk("ba_odd_count", 64'(n_ba_wr), 64'(ba_before + 1));
        chk("lit_pair_addr", 64'(last_b.a), 64'h0);
        chk("lit_pair_word", last_b.w, 64'h0021_0842_0010_8421);

        // Full run without in_last ends on the count.
        do_start();
        for (int i = 0; i < NK; i++)
            send_rec(7'(i % 6), 5'(i % 3), 5'((i * 5) % 32), 5'(31 - (i % 2)), 5'(i % 32), 1'b0);
        chk("full_done", 64'(done), 64'h1);
        chk("full_count", 64'(kmer_count), 64'd208);
        chk("full_sat_clamp", 64'(sat_hits), 64'd255);
        repeat (3) @(negedge clk);
        chk("full_ready_low", 64'(in_ready), 64'h0);

        // Reset while the read data is being captured.
        do_start();
        @(negedge clk);
        in_valid = 1'b1; in_last = 1'b1;
        l0 = 7'd20; l1 = 5'd1; l2 = 5'd2; l3 = 5'd3; l4 = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_bars", 64'({CSB1, WEB1, OEB1, CSB1_ba, WEB1_ba}), 64'h1f);
        chk("mid_rst_flags", 64'({in_ready, busy, done}), 64'h0);
        chk("mid_rst_counts", 64'({kmer_count, sat_hits}), 64'h0);
        chk("mid_rst_data", 64'(address) | datain1 | datain_ba, 64'h0);
        @(negedge clk);
        chk("mid_rst_no_write", 64'({CSB1, WEB1, CSB1_ba, WEB1_ba}), 64'hf);
        reset = 1'b0;
        do_start();
        send_rec(7'd3, 5'd4, 5'd5, 5'd6, 5'd7, 1'b1);
        chk("after_rst_done", 64'(done), 64'h1);
        chk("after_rst_count", 64'(kmer_count), 64'h1);

        repeat (2) @(negedge clk);
        chk("exp_port_drained", 64'(exp_p.size()), 64'h0);
        chk("exp_ba_drained", 64'(exp_b.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
